addsub_arbiter: RTL and testbench

//  Shares one 16-bit saturating add/sub unit (existing CLA_16b) between two requesters,
//  e.g. ALU execute and address calc. Round-robin arbitration, valid/ready on both sides.
//  One-entry registered response slot; maintains the architectural NZV flag register.

---
 rtl/addsub_arbiter_pkg.sv | 26 ++
 rtl/CLA_16b.sv | 71 +++++++
 rtl/addsub_arbiter_rr_arb2.sv | 37 +++
 rtl/addsub_arbiter.sv | 89 ++++++++
 tb/tb_addsub_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/addsub_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// addsub_arbiter_pkg : shared constants for the arbitrated add/sub unit
// Revision: 1.0
// ---------------------------------------------------------------------------
package addsub_arbiter_pkg;

  localparam int unsigned C_DATA_W = 16;
  localparam int unsigned C_FLAG_W = 3;

  // Flag vector layout is {N,Z,V}
  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;

  localparam logic [C_DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [C_DATA_W-1:0] SAT_NEG = 16'h8000;

  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_ADDR = 1'b1;

  typedef logic [C_DATA_W-1:0] data_t;
  typedef logic [C_FLAG_W-1:0] flag_t;

endpackage : addsub_arbiter_pkg
`default_nettype wire

// File: rtl/CLA_16b.sv
`default_nettype none
// ---------------------------------------------------------------------------
// CLA_16b : 16-bit carry-lookahead adder with signed saturation and NZV flags
// Revision: 1.0
// ---------------------------------------------------------------------------
module CLA_16b
  import addsub_arbiter_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] result,
  output logic [2:0]  flag
);

  logic [15:0] w_gen;
  logic [15:0] w_prop;
  logic [16:0] w_carry;
  logic [3:0]  w_grp_gen;
  logic [3:0]  w_grp_prop;
  logic [4:0]  w_grp_carry;
  logic [15:0] w_raw;
  logic        w_ovf;

  assign w_gen  = a & b;
  assign w_prop = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      assign w_grp_prop[gi] = &w_prop[4*gi +: 4];
      assign w_grp_gen[gi]  = w_gen[4*gi+3]
                            | (w_prop[4*gi+3] & w_gen[4*gi+2])
                            | (w_prop[4*gi+3] & w_prop[4*gi+2] & w_gen[4*gi+1])
                            | (w_prop[4*gi+3] & w_prop[4*gi+2] & w_prop[4*gi+1] & w_gen[4*gi]);
    end
  endgenerate

  // Group carries look ahead; carries inside a nibble ripple from the group carry-in
  always_comb begin
    w_grp_carry    = '0;
    w_carry        = '0;
    w_grp_carry[0] = sub;
    for (int k = 0; k < 4; k++) begin
      w_grp_carry[k+1] = w_grp_gen[k] | (w_grp_prop[k] & w_grp_carry[k]);
    end
    for (int k = 0; k < 4; k++) begin
      w_carry[4*k] = w_grp_carry[k];
      for (int j = 0; j < 3; j++) begin
        w_carry[4*k+j+1] = w_gen[4*k+j] | (w_prop[4*k+j] & w_carry[4*k+j]);
      end
    end
    w_carry[16] = w_grp_carry[4];
  end

  assign w_raw = w_prop ^ w_carry[15:0];
  assign w_ovf = (a[15] == b[15]) && (w_raw[15] != a[15]);

  always_comb begin
    result = w_raw;
    if (w_ovf) begin
      result = a[15] ? SAT_NEG : SAT_POS;
    end
    flag         = '0;
    flag[FLAG_N] = result[15];
    flag[FLAG_Z] = (result == 16'h0000);
    flag[FLAG_V] = w_ovf;
  end

endmodule : CLA_16b
`default_nettype wire

// File: rtl/addsub_arbiter_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter; priority rotates only on accept
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arb2
  import addsub_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic r_last_grant;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (r_last_grant == REQ_ADDR) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= REQ_ADDR;
    end else if (accept) begin
      r_last_grant <= grant[1];
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// addsub_arbiter : shares one saturating add/sub unit between two requesters
// Revision: 1.0
// ---------------------------------------------------------------------------
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 16,  // fixed by CLA_16b
  parameter int unsigned FLAG_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [1:0]          req_sub,
  input  logic [1:0]          req_setf,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [FLAG_W-1:0]   rsp_flag,
  output logic                rsp_id,
  output logic [FLAG_W-1:0]   flag_q
);

  logic [1:0]        w_grant;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_sel;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic              w_op_sub;
  logic              w_op_setf;
  logic [DATA_W-1:0] w_result;
  logic [FLAG_W-1:0] w_flag;

  // Nothing is accepted while reset is held, so no op survives into the reset state
  assign w_slot_free = ~rsp_valid | rsp_ready;
  assign req_ready   = rst ? 2'b00 : (w_grant & {2{w_slot_free}});
  assign w_accept    = |(req_valid & req_ready);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .accept (w_accept),
    .grant  (w_grant)
  );

  assign w_sel     = w_grant[1];
  assign w_op_a    = w_sel ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign w_op_sub  = w_sel ? req_sub[1]  : req_sub[0];
  assign w_op_setf = w_sel ? req_setf[1] : req_setf[0];
  assign w_op_b    = (w_sel ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0])
                   ^ {DATA_W{w_op_sub}};

  CLA_16b u_cla (
    .a      (w_op_a),
    .b      (w_op_b),
    .sub    (w_op_sub),
    .result (w_result),
    .flag   (w_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flag  <= '0;
      rsp_id    <= REQ_ALU;
      flag_q    <= '0;
    end else if (w_accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= w_result;
      rsp_flag  <= w_flag;
      rsp_id    <= w_sel;
      if (w_op_setf) begin
        flag_q <= w_flag;
      end
    end else if (rsp_ready) begin
      // Data and flags are left as-is so the outputs never go unknown
      rsp_valid <= 1'b0;
    end
  end

endmodule : addsub_arbiter
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_addsub_arbiter : directed self-checking bench for addsub_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_addsub_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_sub;
  logic [1:0]  req_setf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flag;
  logic        rsp_id;
  logic [2:0]  flag_q;

  int n_compared;
  int n_mismatched;

  addsub_arbiter #(.DATA_W(16), .FLAG_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_setf  (req_setf),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flag  (rsp_flag),
    .rsp_id    (rsp_id),
    .flag_q    (flag_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic vld, input logic [15:0] data,
                           input logic [2:0] flag, input logic id);
    check({tag, ".valid"}, {31'd0, rsp_valid}, {31'd0, vld});
    check({tag, ".data"},  {16'd0, rsp_data},  {16'd0, data});
    check({tag, ".flag"},  {29'd0, rsp_flag},  {29'd0, flag});
    check({tag, ".id"},    {31'd0, rsp_id},    {31'd0, id});
  endtask

  // Expected ids/data for the alternating tie sequence
  logic        exp_id  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] exp_dat [4] = '{16'h0003, 16'h0030, 16'h0003, 16'h0030};

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst       = 1'b1;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_sub   = 2'b00;
    req_setf  = 2'b00;
    rsp_ready = 1'b1;

    // Reset state
    step();
    step();
    check_rsp("reset", 1'b0, 16'h0000, 3'b000, 1'b0);
    check("reset.flag_q",    {29'd0, flag_q},    32'd0);
    check("reset.req_ready", {30'd0, req_ready}, 32'd0);

    // 3 + 4 from requester 0
    rst       = 1'b0;
    req_valid = 2'b01;
    req_a     = {16'h0000, 16'h0003};
    req_b     = {16'h0000, 16'h0004};
    #1;
    check("add.req_ready", {30'd0, req_ready}, 32'h1);
    step();
    check_rsp("add", 1'b1, 16'h0007, 3'b000, 1'b0);

    // 0x8000 - 1 saturates negative
    req_a   = {16'h0000, 16'h8000};
    req_b   = {16'h0000, 16'h0001};
    req_sub = 2'b01;
    step();
    check_rsp("sub_sat", 1'b1, 16'h8000, 3'b101, 1'b0);
    check("sub_sat.flag_q", {29'd0, flag_q}, 32'd0);

    // 5 - 5 = 0
    req_a = {16'h0000, 16'h0005};
    req_b = {16'h0000, 16'h0005};
    step();
    check_rsp("sub_zero", 1'b1, 16'h0000, 3'b010, 1'b0);

    // 0x7FFF + 1 from requester 1 saturates positive and sets flags
    req_valid = 2'b10;
    req_sub   = 2'b00;
    req_setf  = 2'b10;
    req_a     = {16'h7FFF, 16'h0000};
    req_b     = {16'h0001, 16'h0000};
    step();
    check_rsp("add_sat", 1'b1, 16'h7FFF, 3'b001, 1'b1);
    check("add_sat.flag_q", {29'd0, flag_q}, 32'h1);

    // Both valid: last grant was requester 1, so alternation starts at 0
    req_valid = 2'b11;
    req_setf  = 2'b00;
    req_a     = {16'h0010, 16'h0001};
    req_b     = {16'h0020, 16'h0002};
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d.req_ready", i), {30'd0, req_ready},
            exp_id[i] ? 32'h2 : 32'h1);
      step();
      check_rsp($sformatf("rr%0d", i), 1'b1, exp_dat[i], 3'b000, exp_id[i]);
    end
    check("rr.flag_q", {29'd0, flag_q}, 32'h1);

    // Back-pressure for 3 cycles: slot holds requester-1 result, nothing accepted
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d.req_ready", i), {30'd0, req_ready}, 32'h0);
      step();
      check_rsp($sformatf("bp%0d", i), 1'b1, 16'h0030, 3'b000, 1'b1);
    end
    rsp_ready = 1'b1;
    #1;
    check("drain.req_ready", {30'd0, req_ready}, 32'h1);
    step();
    check_rsp("drain0", 1'b1, 16'h0003, 3'b000, 1'b0);
    step();
    check_rsp("drain1", 1'b1, 16'h0030, 3'b000, 1'b1);

    // Load flag_q with 101, then reset with the slot full
    req_valid = 2'b01;
    req_a     = {16'h0000, 16'h8000};
    req_b     = {16'h0000, 16'h0001};
    req_sub   = 2'b01;
    req_setf  = 2'b01;
    step();
    check_rsp("pre_rst", 1'b1, 16'h8000, 3'b101, 1'b0);
    check("pre_rst.flag_q", {29'd0, flag_q}, 32'h5);

    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    #1;
    check("rst.req_ready", {30'd0, req_ready}, 32'h0);
    step();
    check_rsp("mid_rst", 1'b0, 16'h0000, 3'b000, 1'b0);
    check("mid_rst.flag_q", {29'd0, flag_q}, 32'h0);

    // First tie after reset goes to requester 0
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_sub   = 2'b00;
    req_setf  = 2'b00;
    req_a     = {16'h0002, 16'h0001};
    req_b     = {16'h0002, 16'h0001};
    #1;
    check("post_rst.req_ready", {30'd0, req_ready}, 32'h1);
    step();
    check_rsp("post_rst", 1'b1, 16'h0002, 3'b000, 1'b0);

    req_valid = 2'b00;
    step();
    check("idle.valid", {31'd0, rsp_valid}, 32'h0);
    check("idle.data",  {16'd0, rsp_data},  32'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_addsub_arbiter
`default_nettype wire
